alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the 16-bit ALU adder (sum Z plus S/ZR/CY/P/V flags).
//  Captures each result with its flags into a 2-entry FIFO with valid/ready handshake on both sides,
//  so the adder never stalls on a slow consumer. Keeps sticky carry/overflow status for the control unit.
// PARAMETERS
//  WIDTH   16  data width of the result word (matches adder Z)
//  CNT_W   8   width of the overflow event counter (used only with ALU_OVF_COUNT_EN)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      adder result on in_z/in_flags is valid
//  in_ready   out  1      stage can accept an entry this cycle
//  in_z       in   WIDTH  adder sum
//  in_flags   in   5      {Sign, Zero, Carry, Parity, Overflow}, as produced by the adder
//  out_valid  out  1      out_z/out_flags hold the oldest stored entry
//  out_ready  in   1      consumer takes the entry this cycle
//  out_z      out  WIDTH  head-entry sum
//  out_flags  out  5      head-entry flags, same bit order as in_flags
//  clr_sticky in   1      synchronous clear of sticky status (and counter)
//  stk_carry  out  1      set once any accepted entry had Carry=1
//  stk_ovf    out  1      set once any accepted entry had Overflow=1
//  ovf_cnt    out  CNT_W  accepted entries with Overflow=1 (only with ALU_OVF_COUNT_EN)
// BEHAVIOUR
//  - Reset (async, rst=1): FIFO count=0, out_valid=0, out_z=0, out_flags=0, stk_carry=0, stk_ovf=0,
//    ovf_cnt=0, in_ready=0. Stored entries are discarded; reset mid-transfer loses them, no partial pop.
//  - in_ready = !rst && (count != 2); depends only on registered state, never on out_ready.
//  - push = in_valid && in_ready; pop = out_valid && out_ready. Evaluated at the rising edge.
//  - in_valid while in_ready=0 is ignored: no capture, no sticky/counter update.
//  - Storage: 2 entries of WIDTH+5 bits, write/read pointers (1 bit each), count 0..2.
//    Pointers wrap 1->0. Strict FIFO order; flags always travel with their own sum.
//  - Count states: EMPTY(0) -push-> ONE(1); ONE -push&!pop-> FULL(2); ONE -pop&!push-> EMPTY;
//    ONE -push&pop-> ONE; FULL -pop-> ONE (push impossible when FULL).
//  - out_valid = (count != 0); out_z/out_flags driven from the read-pointer entry; 0 when EMPTY.
//  - Latency: entry pushed at edge N is on out_* with out_valid=1 from edge N (visible cycle N+1)
//    if FIFO was empty. Throughput 1 entry/cycle with out_ready held high.
//  - Data values are held stable while out_valid=1 and out_ready=0.
//  - Sticky: on push, stk_carry |= in_flags[2]; stk_ovf |= in_flags[0].
//    clr_sticky clears both; clr_sticky and a setting push in the same cycle -> bit ends 1 (set wins).
//  - No arithmetic on data; sum and flags pass through bit-exact.
// CONFIGURATION
//  ALU_OVF_COUNT_EN defined: ovf_cnt increments on each push with in_flags[0]=1, saturates at
//    2^CNT_W-1 (no wrap); clr_sticky resets it to 0; clear+overflow push same cycle -> ovf_cnt=1.
//  ALU_OVF_COUNT_EN undefined: no counter logic; ovf_cnt port present and tied to 0.
// TESTING
//  1. Reset: rst=1 mid-run with 2 entries stored -> out_valid=0, in_ready=0, sticky=0; rst=0 -> in_ready=1.
//  2. Single pass: push in_z=16'h0fff, in_flags=5'b00101, out_ready=1 -> next cycle out_z=16'h0fff,
//     out_flags=5'b00101, out_valid=1 for one cycle; stk_carry=1, stk_ovf=1.
//  3. Backpressure: out_ready=0, push 16'h0000/5'b01100 then 16'h0000/5'b11000 -> in_ready=0;
//     third push (16'h8000) ignored; release out_ready -> outputs in order, then in_ready=1.
//  4. Streaming: out_ready=1, push 8 consecutive words 16'h0001..16'h0008 -> same order out, 1/cycle,
//     in_ready never drops.
//  5. Sticky clear: stk_ovf=1, clr_sticky=1 with push of in_flags=5'b00001 -> stk_ovf stays 1;
//     clr_sticky alone next cycle -> stk_ovf=0, stk_carry=0.
//  6. ALU_OVF_COUNT_EN, CNT_W=2: 5 pushes with Overflow=1 -> ovf_cnt 1,2,3,3,3; clr_sticky -> 0;
//     without macro ovf_cnt=0 throughout.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry result/flag FIFO behind the ALU adder with sticky carry/overflow status
// Optional feature: define ALU_OVF_COUNT_EN to build the saturating overflow event counter on ovf_cnt.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_z,
  input  logic [4:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [4:0]       out_flags,
  input  logic             clr_sticky,
  output logic             stk_carry,
  output logic             stk_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);
  logic [WIDTH+4:0] r_mem [0:1];
  logic             r_wp;
  logic             r_rp;
  logic [1:0]       r_cnt;
  logic             r_stk_carry;
  logic             r_stk_ovf;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH+4:0] w_head;
  assign in_ready  = !rst && (r_cnt != 2'd2);
  assign out_valid = r_cnt != 2'd0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rp];
  assign out_z     = out_valid ? w_head[WIDTH+4:5] : '0;
  assign out_flags = out_valid ? w_head[4:0] : 5'd0;
  assign stk_carry = r_stk_carry;
  assign stk_ovf   = r_stk_ovf;
  // FIFO storage, pointers and occupancy; sum and flags are stored together so they never separate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '{default: '0};
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {in_z, in_flags};
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
  // Sticky status: a setting push in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stk_carry <= 1'b0;
      r_stk_ovf   <= 1'b0;
    end else begin
      r_stk_carry <= (r_stk_carry && !clr_sticky) || (w_push && in_flags[2]);
      r_stk_ovf   <= (r_stk_ovf && !clr_sticky) || (w_push && in_flags[0]);
    end
  end
`ifdef ALU_OVF_COUNT_EN
  logic [CNT_W-1:0] r_ovf_cnt;
  logic             w_ovf_push;
  assign w_ovf_push = w_push && in_flags[0];
  assign ovf_cnt    = r_ovf_cnt;
  // Saturating overflow counter; a clear that coincides with an overflow push leaves a count of one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf_cnt <= '0;
    else if (clr_sticky) r_ovf_cnt <= w_ovf_push ? CNT_W'(1) : '0;
    else if (w_ovf_push && r_ovf_cnt != {CNT_W{1'b1}}) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
  end
`else
  assign ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed-vector bench for alu_result_stage
module tb_alu_result_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_z = '0;
  logic [4:0]  in_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_z;
  logic [4:0]  out_flags;
  logic        clr_sticky = 1'b0;
  logic        stk_carry;
  logic        stk_ovf;
  logic [1:0]  ovf_cnt;
  int          checks = 0;
  int          failures = 0;
  alu_result_stage #(.WIDTH(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
    .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_flags(out_flags), .clr_sticky(clr_sticky), .stk_carry(stk_carry), .stk_ovf(stk_ovf),
    .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [1:0] exp_cnt(input int n);
`ifdef ALU_OVF_COUNT_EN
    return (n > 3) ? 2'd3 : 2'(n);
`else
    return 2'd0;
`endif
  endfunction
  initial begin
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_stk_carry", stk_carry, 0);
    chk("rst_stk_ovf", stk_ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    // single pass
    out_ready = 1'b1;
    in_valid = 1'b1; in_z = 16'h0fff; in_flags = 5'b00101;
    step();
    in_valid = 1'b0;
    chk("sp_out_valid", out_valid, 1);
    chk("sp_out_z", out_z, 16'h0fff);
    chk("sp_out_flags", out_flags, 5'b00101);
    chk("sp_stk_carry", stk_carry, 1);
    chk("sp_stk_ovf", stk_ovf, 1);
    chk("sp_ovf_cnt", ovf_cnt, exp_cnt(1));
    step();
    chk("sp_drained", out_valid, 0);
    chk("sp_empty_z", out_z, 0);
    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_z = 16'h0000; in_flags = 5'b01100;
    step();
    chk("bp_one_ready", in_ready, 1);
    chk("bp_one_flags", out_flags, 5'b01100);
    in_flags = 5'b11000;
    step();
    chk("bp_full_ready", in_ready, 0);
    in_z = 16'h8000; in_flags = 5'b00001;
    step();
    chk("bp_ign_ready", in_ready, 0);
    chk("bp_hold_flags", out_flags, 5'b01100);
    chk("bp_hold_z", out_z, 16'h0000);
    chk("bp_ign_ovf_cnt", ovf_cnt, exp_cnt(1));
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_second_flags", out_flags, 5'b11000);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_after_ready", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);
    // streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_z = 16'(i); in_flags = 5'b00000;
      #1;
      chk("st_in_ready", in_ready, 1);
      step();
      chk("st_out_z", out_z, i);
      chk("st_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    chk("st_empty", out_valid, 0);
    // sticky clear with coincident setting push
    clr_sticky = 1'b1; in_valid = 1'b1; in_z = 16'h1234; in_flags = 5'b00001;
    step();
    chk("sc_set_wins", stk_ovf, 1);
    chk("sc_carry_clr", stk_carry, 0);
    chk("sc_cnt_one", ovf_cnt, exp_cnt(1));
    in_valid = 1'b0;
    step();
    clr_sticky = 1'b0;
    chk("sc_ovf_clr", stk_ovf, 0);
    chk("sc_carry_stay", stk_carry, 0);
    chk("sc_cnt_zero", ovf_cnt, 0);
    // overflow counter saturation
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_z = 16'h7fff; in_flags = 5'b00001;
      step();
      chk("oc_count", ovf_cnt, exp_cnt(i));
    end
    in_valid = 1'b0; clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("oc_clr", ovf_cnt, 0);
    // reset mid-run with two entries stored
    out_ready = 1'b0;
    in_valid = 1'b1; in_z = 16'haaaa; in_flags = 5'b00100;
    step();
    in_z = 16'h5555; in_flags = 5'b00001;
    step();
    in_valid = 1'b0;
    chk("mr_full", in_ready, 0);
    chk("mr_carry_set", stk_carry, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_stk_carry", stk_carry, 0);
    chk("mr_stk_ovf", stk_ovf, 0);
    step();
    #2 rst = 1'b0;
    #1;
    chk("mr_rel_ready", in_ready, 1);
    chk("mr_rel_valid", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
